main_mem_arb: RTL and testbench

//  Parametrised successor to the NES main memory front end. Arbitrates N requestor

---
 rtl/main_mem_pkg.sv | 39 +++
 rtl/generic_ram.sv | 23 ++
 rtl/mem_rr_arb.sv | 47 ++++
 rtl/main_mem_arb.sv | 186 ++++++++++++++++++
 tb/tb_main_mem_arb.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/main_mem_pkg.sv
// rtl/main_mem_pkg.sv - shared types, encodings and region decode for the main memory arbiter
package main_mem_pkg;

    typedef enum logic [2:0] {
        RG_PRG,
        RG_CHR,
        RG_VRAM,
        RG_UNMAP,
        RG_CRAM,
        RG_CARTRAM
    } region_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CART_REQ,
        S_CART_WAIT
    } state_t;

    localparam logic [1:0]  CSEL_PRG  = 2'b00;
    localparam logic [1:0]  CSEL_CHR  = 2'b01;
    localparam logic [1:0]  CSEL_CRAM = 2'b10;
    localparam logic [63:0] ALL_ONES  = '1;

    function automatic region_t decode_region(input logic [3:0] top);
        casez (top)
            4'b0???: return RG_PRG;
            4'b10??: return RG_CHR;
            4'b1100: return RG_VRAM;
            4'b1101: return RG_UNMAP;
            4'b1110: return RG_CRAM;
            default: return RG_CARTRAM;
        endcase
    endfunction

    function automatic logic is_cart(input region_t r);
        return (r == RG_PRG) || (r == RG_CHR) || (r == RG_CARTRAM);
    endfunction

endpackage

// File: rtl/generic_ram.sv
// rtl/generic_ram.sv - single-port RAM, synchronous write, registered read
module generic_ram #(
    parameter int WORDS  = 2048,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/mem_rr_arb.sv
// rtl/mem_rr_arb.sv - one-hot grant picker, round-robin or fixed priority
module mem_rr_arb #(
    parameter int N_PORTS   = 2,
    parameter int PRIO_MODE = 0,
    localparam int PW       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_PORTS-1:0] i_eligible,
    input  logic               i_grant_en,
    output logic [N_PORTS-1:0] o_grant,
    output logic [PW-1:0]      o_grant_idx,
    output logic               o_grant_any
);

    logic [PW-1:0] r_last;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_cand;
    logic          w_found;

    // Search starts just past the last winner so every port gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_cand = (PRIO_MODE == 1) ? PW'(i) : PW'((int'(r_last) + 1 + i) % N_PORTS);
            if (!w_found && i_eligible[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign o_grant_any = i_grant_en & w_found;
    assign o_grant_idx = w_idx;
    assign o_grant     = o_grant_any ? (N_PORTS'(1) << w_idx) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= PW'(N_PORTS - 1);
        end else if (o_grant_any) begin
            r_last <= w_idx;
        end
    end

endmodule

// File: rtl/main_mem_arb.sv
// rtl/main_mem_arb.sv - N-port arbiter onto internal CPU-RAM/VRAM and a stallable cart interface
module main_mem_arb
    import main_mem_pkg::*;
#(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 8,
    parameter int N_PORTS   = 2,
    parameter int RAM_WORDS = 2048,
    parameter int PRIO_MODE = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_load_done,
    input  logic [N_PORTS-1:0]          i_req_valid,
    output logic [N_PORTS-1:0]          o_req_ready,
    input  logic [N_PORTS-1:0]          i_req_we,
    input  logic [N_PORTS*ADDR_W-1:0]   i_req_addr,
    input  logic [N_PORTS*DATA_W-1:0]   i_req_wdata,
    output logic [N_PORTS-1:0]          o_rsp_valid,
    output logic [N_PORTS*DATA_W-1:0]   o_rsp_data,
    output logic                        o_cart_valid,
    input  logic                        i_cart_ready,
    output logic [1:0]                  o_cart_sel,
    output logic [ADDR_W-2:0]           o_cart_addr,
    output logic                        o_cart_we,
    output logic [DATA_W-1:0]           o_cart_wdata,
    input  logic                        i_cart_rvalid,
    input  logic [DATA_W-1:0]           i_cart_rdata
);

    localparam int PW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SEG_W  = ADDR_W - 1;

    state_t                r_state, w_state_nxt;
    logic [N_PORTS-1:0]    w_elig, w_grant;
    logic [PW-1:0]         w_gidx;
    logic                  w_gany;
    logic [ADDR_W-1:0]     w_gaddr;
    logic                  w_gwe;
    logic [DATA_W-1:0]     w_gwdata;
    region_t               w_greg;
    logic                  w_gcart;
    logic [SEG_W-1:0]      w_seg;
    logic [1:0]            w_sel;
    logic [DATA_W-1:0]     w_vram_rdata, w_cram_rdata, w_rsp_word;

    logic                  r_rd_pend;
    logic [PW-1:0]         r_rd_port;
    region_t               r_rd_src;
    logic [1:0]            r_cart_sel;
    logic [SEG_W-1:0]      r_cart_addr;
    logic                  r_cart_we;
    logic [DATA_W-1:0]     r_cart_wdata;
    logic [PW-1:0]         r_cart_own;
    logic                  r_crsp;
    logic [DATA_W-1:0]     r_crsp_data;
    logic [N_PORTS*DATA_W-1:0] r_rsp_data;

    always_comb begin
        w_elig = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            w_elig[p] = i_req_valid[p] &
                (!is_cart(decode_region(i_req_addr[p*ADDR_W + ADDR_W - 4 +: 4])) | i_load_done);
        end
    end

    mem_rr_arb #(.N_PORTS(N_PORTS), .PRIO_MODE(PRIO_MODE)) u_arb (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_eligible  (w_elig),
        .i_grant_en  ((r_state == S_IDLE) & i_rst_n),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_grant_any (w_gany)
    );

    assign o_req_ready = w_grant;
    assign w_gaddr     = i_req_addr[w_gidx*ADDR_W +: ADDR_W];
    assign w_gwe       = i_req_we[w_gidx];
    assign w_gwdata    = i_req_wdata[w_gidx*DATA_W +: DATA_W];
    assign w_greg      = decode_region(w_gaddr[ADDR_W-1 -: 4]);
    assign w_gcart     = w_gany & is_cart(w_greg);

    always_comb begin
        case (w_greg)
            RG_PRG:  begin w_seg = w_gaddr[SEG_W-1:0];          w_sel = CSEL_PRG;  end
            RG_CHR:  begin w_seg = SEG_W'(w_gaddr[ADDR_W-3:0]); w_sel = CSEL_CHR;  end
            default: begin w_seg = SEG_W'(w_gaddr[ADDR_W-5:0]); w_sel = CSEL_CRAM; end
        endcase
    end

    generic_ram #(.WORDS(RAM_WORDS), .DATA_W(DATA_W)) u_vram (
        .i_clk   (i_clk),
        .i_we    (w_gany & w_gwe & (w_greg == RG_VRAM)),
        .i_addr  (w_gaddr[RAM_AW-1:0]),
        .i_wdata (w_gwdata),
        .o_rdata (w_vram_rdata)
    );

    generic_ram #(.WORDS(RAM_WORDS), .DATA_W(DATA_W)) u_cram (
        .i_clk   (i_clk),
        .i_we    (w_gany & w_gwe & (w_greg == RG_CRAM)),
        .i_addr  (w_gaddr[RAM_AW-1:0]),
        .i_wdata (w_gwdata),
        .o_rdata (w_cram_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_gcart)       w_state_nxt = S_CART_REQ;
            S_CART_REQ:  if (i_cart_ready)  w_state_nxt = r_cart_we ? S_IDLE : S_CART_WAIT;
            S_CART_WAIT: if (i_cart_rvalid) w_state_nxt = S_IDLE;
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_pend    <= 1'b0;
            r_rd_port    <= '0;
            r_rd_src     <= RG_UNMAP;
            r_cart_sel   <= CSEL_PRG;
            r_cart_addr  <= '0;
            r_cart_we    <= 1'b0;
            r_cart_wdata <= '0;
            r_cart_own   <= '0;
            r_crsp       <= 1'b0;
            r_crsp_data  <= '0;
            r_rsp_data   <= '0;
        end else begin
            r_rd_pend  <= w_gany & !w_gwe & !is_cart(w_greg);
            r_rd_port  <= w_gidx;
            r_rd_src   <= w_greg;
            r_crsp     <= (r_state == S_CART_WAIT) & i_cart_rvalid;
            r_rsp_data <= o_rsp_data;
            if (w_gcart) begin
                r_cart_sel   <= w_sel;
                r_cart_addr  <= w_seg;
                r_cart_we    <= w_gwe;
                r_cart_wdata <= w_gwdata;
                r_cart_own   <= w_gidx;
            end
            if ((r_state == S_CART_WAIT) && i_cart_rvalid) begin
                r_crsp_data <= i_cart_rdata;
            end
        end
    end

    // RAM data is only valid in the cycle after the read, so it bypasses the hold register.
    always_comb begin
        o_rsp_valid = '0;
        o_rsp_data  = '0;
        if (r_crsp) begin
            w_rsp_word = r_crsp_data;
        end else if (r_rd_src == RG_VRAM) begin
            w_rsp_word = w_vram_rdata;
        end else if (r_rd_src == RG_CRAM) begin
            w_rsp_word = w_cram_rdata;
        end else begin
            w_rsp_word = ALL_ONES[DATA_W-1:0];
        end
        for (int p = 0; p < N_PORTS; p++) begin
            o_rsp_valid[p] = (r_rd_pend && (r_rd_port == PW'(p))) ||
                             (r_crsp && (r_cart_own == PW'(p)));
            o_rsp_data[p*DATA_W +: DATA_W] = o_rsp_valid[p] ? w_rsp_word
                                                            : r_rsp_data[p*DATA_W +: DATA_W];
        end
    end

    assign o_cart_valid = (r_state == S_CART_REQ);
    assign o_cart_sel   = r_cart_sel;
    assign o_cart_addr  = r_cart_addr;
    assign o_cart_we    = r_cart_we;
    assign o_cart_wdata = r_cart_wdata;

endmodule

// File: tb/tb_main_mem_arb.sv
// tb/tb_main_mem_arb.sv - directed bench, round-robin and fixed-priority instances on shared stimulus
module tb_main_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n, load_done;
    logic [1:0]  req_valid, req_we;
    logic [43:0] req_addr;
    logic [15:0] req_wdata;
    logic        cart_ready, cart_rvalid;
    logic [7:0]  cart_rdata;

    logic [1:0]  rdy0, rsp_v0, csel0, rdy1, rsp_v1, csel1;
    logic [15:0] rsp_d0, rsp_d1;
    logic        cv0, cwe0, cv1, cwe1;
    logic [20:0] caddr0, caddr1;
    logic [7:0]  cwd0, cwd1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    main_mem_arb #(.PRIO_MODE(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_done(load_done),
        .i_req_valid(req_valid), .o_req_ready(rdy0), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_v0), .o_rsp_data(rsp_d0),
        .o_cart_valid(cv0), .i_cart_ready(cart_ready), .o_cart_sel(csel0),
        .o_cart_addr(caddr0), .o_cart_we(cwe0), .o_cart_wdata(cwd0),
        .i_cart_rvalid(cart_rvalid), .i_cart_rdata(cart_rdata)
    );

    main_mem_arb #(.PRIO_MODE(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_done(load_done),
        .i_req_valid(req_valid), .o_req_ready(rdy1), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_v1), .o_rsp_data(rsp_d1),
        .o_cart_valid(cv1), .i_cart_ready(cart_ready), .o_cart_sel(csel1),
        .o_cart_addr(caddr1), .o_cart_we(cwe1), .o_cart_wdata(cwd1),
        .i_cart_rvalid(cart_rvalid), .i_cart_rdata(cart_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setp(input int p, input logic v, input logic we,
                        input logic [21:0] a, input logic [7:0] d);
        req_valid[p]         = v;
        req_we[p]            = we;
        req_addr[p*22 +: 22] = a;
        req_wdata[p*8 +: 8]  = d;
    endtask

    initial begin
        rst_n = 1'b0; load_done = 1'b0; req_valid = '0; req_we = '0;
        req_addr = '0; req_wdata = '0; cart_ready = 1'b0; cart_rvalid = 1'b0; cart_rdata = '0;
        setp(0, 1'b1, 1'b0, 22'h380010, 8'h00);
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy0), 32'h0);
        chk("rst_cart_valid", 32'(cv0), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_v0), 32'h0);
        chk("rst_rsp_data", 32'(rsp_d0), 32'h0);
        rst_n = 1'b1;

        // load gating and first read latency
        setp(0, 1'b1, 1'b1, 22'h380010, 8'hFF);
        setp(1, 1'b1, 1'b0, 22'h000123, 8'h00);
        #1 chk("t1_wr_grant", 32'(rdy0), 32'h1);
        @(negedge clk);
        setp(0, 1'b1, 1'b0, 22'h380010, 8'h00);
        #1 chk("t1_rd_grant", 32'(rdy0), 32'h1);
        @(negedge clk);
        setp(0, 1'b0, 1'b0, 22'h0, 8'h00);
        #1 chk("t1_rsp_valid", 32'(rsp_v0), 32'h1);
        chk("t1_rsp_data", 32'(rsp_d0[7:0]), 32'hFF);
        chk("t1_prg_held", 32'(rdy0), 32'h0);
        load_done = 1'b1;
        #1 chk("t1_prg_grant", 32'(rdy0), 32'h2);
        @(negedge clk);
        setp(1, 1'b0, 1'b0, 22'h0, 8'h00);
        #1 chk("t1_cart_valid", 32'(cv0), 32'h1);
        chk("t1_cart_sel", 32'(csel0), 32'h0);
        chk("t1_cart_addr", 32'(caddr0), 32'h000123);
        chk("t1_no_grant", 32'(rdy0), 32'h0);
        cart_ready = 1'b1;
        @(negedge clk);
        cart_ready = 1'b0;
        #1 chk("t1_wait_valid", 32'(cv0), 32'h0);
        cart_rvalid = 1'b1; cart_rdata = 8'h77;
        @(negedge clk);
        cart_rvalid = 1'b0;
        #1 chk("t1_cart_rsp_valid", 32'(rsp_v0), 32'h2);
        chk("t1_cart_rsp_data", 32'(rsp_d0[15:8]), 32'h77);

        // arbitration modes
        @(negedge clk);
        setp(0, 1'b1, 1'b0, 22'h380010, 8'h00);
        setp(1, 1'b1, 1'b0, 22'h380011, 8'h00);
        #1 chk("t2_rr_g0", 32'(rdy0), 32'h1);
        chk("t2_fx_g0", 32'(rdy1), 32'h1);
        @(negedge clk);
        #1 chk("t2_rr_g1", 32'(rdy0), 32'h2);
        chk("t2_fx_g1", 32'(rdy1), 32'h1);
        chk("t2_rr_rsp1", 32'(rsp_v0), 32'h1);
        chk("t2_rr_dat1", 32'(rsp_d0[7:0]), 32'hFF);
        @(negedge clk);
        #1 chk("t2_rr_g2", 32'(rdy0), 32'h1);
        chk("t2_fx_g2", 32'(rdy1), 32'h1);
        chk("t2_rr_rsp2", 32'(rsp_v0), 32'h2);
        @(negedge clk);
        #1 chk("t2_rr_g3", 32'(rdy0), 32'h2);
        chk("t2_fx_g3", 32'(rdy1), 32'h1);
        @(negedge clk);
        setp(0, 1'b0, 1'b0, 22'h0, 8'h00);
        setp(1, 1'b0, 1'b0, 22'h0, 8'h00);
        #1 chk("t2_rr_rsp4", 32'(rsp_v0), 32'h2);
        chk("t2_fx_rsp4", 32'(rsp_v1), 32'h1);

        // VRAM wrap
        @(negedge clk);
        setp(0, 1'b1, 1'b1, 22'h300005, 8'hA5);
        #1 chk("t3_wr_grant", 32'(rdy0), 32'h1);
        @(negedge clk);
        setp(0, 1'b1, 1'b0, 22'h300805, 8'h00);
        #1 chk("t3_rd_grant", 32'(rdy0), 32'h1);
        @(negedge clk);
        setp(0, 1'b0, 1'b0, 22'h0, 8'h00);
        #1 chk("t3_rsp_valid", 32'(rsp_v0), 32'h1);
        chk("t3_rsp_data", 32'(rsp_d0[7:0]), 32'hA5);
        @(negedge clk);
        #1 chk("t3_rsp_drop", 32'(rsp_v0), 32'h0);
        chk("t3_rsp_hold", 32'(rsp_d0[7:0]), 32'hA5);

        // stalled cart read
        @(negedge clk);
        setp(0, 1'b1, 1'b0, 22'h012345, 8'h00);
        #1 chk("t4_grant", 32'(rdy0), 32'h1);
        @(negedge clk);
        setp(0, 1'b0, 1'b0, 22'h0, 8'h00);
        setp(1, 1'b1, 1'b0, 22'h380010, 8'h00);
        #1 chk("t4_cart_addr", 32'(caddr0), 32'h012345);
        chk("t4_cart_sel", 32'(csel0), 32'h0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4_valid_held%0d", k), 32'(cv0), 32'h1);
            chk($sformatf("t4_blocked%0d", k), 32'(rdy0), 32'h0);
            @(negedge clk);
            #1;
        end
        cart_ready = 1'b1;
        chk("t4_valid_held3", 32'(cv0), 32'h1);
        @(negedge clk);
        cart_ready = 1'b0;
        #1 chk("t4_valid_drop", 32'(cv0), 32'h0);
        chk("t4_wait_blocked", 32'(rdy0), 32'h0);
        @(negedge clk);
        cart_rvalid = 1'b1; cart_rdata = 8'h5C;
        #1 chk("t4_rvalid_blocked", 32'(rdy0), 32'h0);
        @(negedge clk);
        cart_rvalid = 1'b0;
        #1 chk("t4_rsp_valid", 32'(rsp_v0), 32'h1);
        chk("t4_rsp_data", 32'(rsp_d0[7:0]), 32'h5C);
        chk("t4_p1_grant", 32'(rdy0), 32'h2);
        @(negedge clk);
        setp(1, 1'b0, 1'b0, 22'h0, 8'h00);
        #1 chk("t4_p1_rsp", 32'(rsp_v0), 32'h2);
        chk("t4_p1_data", 32'(rsp_d0[15:8]), 32'hFF);
        chk("t4_p0_hold", 32'(rsp_d0[7:0]), 32'h5C);

        // unmapped region
        @(negedge clk);
        setp(0, 1'b1, 1'b0, 22'h340000, 8'h00);
        #1 chk("t5_grant", 32'(rdy0), 32'h1);
        @(negedge clk);
        setp(0, 1'b1, 1'b1, 22'h340005, 8'h00);
        #1 chk("t5_rsp_valid", 32'(rsp_v0), 32'h1);
        chk("t5_rsp_data", 32'(rsp_d0[7:0]), 32'hFF);
        @(negedge clk);
        setp(0, 1'b1, 1'b0, 22'h340005, 8'h00);
        @(negedge clk);
        setp(0, 1'b1, 1'b0, 22'h300005, 8'h00);
        #1 chk("t5_after_wr", 32'(rsp_d0[7:0]), 32'hFF);
        @(negedge clk);
        setp(0, 1'b0, 1'b0, 22'h0, 8'h00);
        #1 chk("t5_vram_intact", 32'(rsp_d0[7:0]), 32'hA5);

        // reset during cart wait
        @(negedge clk);
        setp(0, 1'b1, 1'b0, 22'h200010, 8'h00);
        #1 chk("t6_grant", 32'(rdy0), 32'h1);
        @(negedge clk);
        setp(0, 1'b0, 1'b0, 22'h0, 8'h00);
        cart_ready = 1'b1;
        #1 chk("t6_cart_valid", 32'(cv0), 32'h1);
        chk("t6_cart_sel", 32'(csel0), 32'h1);
        chk("t6_cart_addr", 32'(caddr0), 32'h000010);
        @(negedge clk);
        cart_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("t6_rst_cart_valid", 32'(cv0), 32'h0);
        chk("t6_rst_rsp_valid", 32'(rsp_v0), 32'h0);
        chk("t6_rst_rsp_data", 32'(rsp_d0), 32'h0);
        cart_rvalid = 1'b1; cart_rdata = 8'h33;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cart_rvalid = 1'b0;
        #1 chk("t6_late_rvalid", 32'(rsp_v0), 32'h0);
        chk("t6_idle_cart", 32'(cv0), 32'h0);
        setp(0, 1'b1, 1'b0, 22'h300005, 8'h00);
        setp(1, 1'b1, 1'b0, 22'h380010, 8'h00);
        #1 chk("t6_first_port0", 32'(rdy0), 32'h1);
        @(negedge clk);
        setp(0, 1'b0, 1'b0, 22'h0, 8'h00);
        setp(1, 1'b0, 1'b0, 22'h0, 8'h00);
        #1 chk("t6_served", 32'(rsp_v0), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
